vend_change_out: RTL and testbench

Output-side controller for the vending FSM. It converts the FSM's credit state into physical actuation: a product-dispense pulse, then change returned one coin at a time. Change coins are driven on the same 2-bit coin code the input encoder produces, so the hopper and the coin acceptor share one coin vocabulary. The block sits between the state-memory registers (credit value) and the product/coin hopper drivers.

---
 rtl/vend_change_out.sv | 189 ++++++++++++++++++
 tb/tb_vend_change_out.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/vend_change_out.sv
// vend_change_out
//   Output-side controller for the vending FSM. It turns the latched credit
//   into physical actuation:
//     1. a product-dispense pulse,
//     2. change paid one coin at a time on the shared 2-bit coin code,
//     3. a credit-clear / done handshake back to the FSM.
//
// Ports
//   clk          : rising-edge clock
//   rst_n        : synchronous active-low reset
//   credit_in    : credit in nickel units; sampled only in IDLE
//   vend_req     : vend request; sampled only in IDLE
//   cancel_req   : refund request; sampled only in IDLE, wins over vend_req
//   hopper_ready : hopper can accept a coin pulse
//   dispense     : product release pulse, PULSE_CYCLES wide
//   coin_out     : 01 nickel, 10 dime, 11 quarter, 00 none
//   coin_valid   : coin pulse active, PULSE_CYCLES wide
//   busy         : block is not in IDLE
//   denied       : one-cycle pulse, vend refused for insufficient credit
//   credit_clr   : one-cycle pulse, FSM must zero its credit
//   done         : one-cycle pulse at transaction end, with credit_clr
`timescale 1ns/1ps

module vend_change_out #(
    parameter int PRICE_N      = 6,
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] credit_in,
    input  logic       vend_req,
    input  logic       cancel_req,
    input  logic       hopper_ready,
    output logic       dispense,
    output logic [1:0] coin_out,
    output logic       coin_valid,
    output logic       busy,
    output logic       denied,
    output logic       credit_clr,
    output logic       done
);

    // One shared down-counter times both the pulses and the gaps.
    localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [3:0]       PRICE    = 4'(PRICE_N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VEND,
        S_CHG_SEL,
        S_COIN,
        S_GAP,
        S_FIN
    } state_t;

    state_t           r_state;
    logic [3:0]       r_remain;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dispense;
    logic [1:0]       r_coin_out;
    logic             r_coin_valid;
    logic             r_busy;
    logic             r_denied;
    logic             r_credit_clr;
    logic             r_done;

    // Largest coin that does not exceed the remaining change.
    function automatic logic [1:0] pick_coin(input logic [3:0] rem);
        if (rem >= 4'd5)      return 2'b11;
        else if (rem >= 4'd2) return 2'b10;
        else                  return 2'b01;
    endfunction

    function automatic logic [3:0] coin_units(input logic [1:0] code);
        case (code)
            2'b01:   return 4'd1;
            2'b10:   return 4'd2;
            2'b11:   return 4'd5;
            default: return 4'd0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_remain     <= '0;
            r_cnt        <= '0;
            r_dispense   <= 1'b0;
            r_coin_out   <= 2'b00;
            r_coin_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_denied     <= 1'b0;
            r_credit_clr <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_denied     <= 1'b0;
            r_credit_clr <= 1'b0;
            r_done       <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (cancel_req) begin
                        r_remain <= credit_in;
                        r_busy   <= 1'b1;
                        r_state  <= S_CHG_SEL;
                    end else if (vend_req) begin
                        if (credit_in >= PRICE) begin
                            r_remain   <= credit_in - PRICE;
                            r_cnt      <= PULSE_LD;
                            r_dispense <= 1'b1;
                            r_busy     <= 1'b1;
                            r_state    <= S_VEND;
                        end else begin
                            r_denied <= 1'b1;
                        end
                    end
                end

                S_VEND: begin
                    if (r_cnt == '0) begin
                        r_dispense <= 1'b0;
                        r_state    <= S_CHG_SEL;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                S_CHG_SEL: begin
                    if (r_remain == 4'd0) begin
                        r_credit_clr <= 1'b1;
                        r_done       <= 1'b1;
                        r_state      <= S_FIN;
                    end else if (hopper_ready) begin
                        r_coin_out   <= pick_coin(r_remain);
                        r_coin_valid <= 1'b1;
                        r_cnt        <= PULSE_LD;
                        r_state      <= S_COIN;
                    end
                end

                // The coin code register doubles as the record of what is
                // being paid, so the subtraction uses it on the last cycle.
                S_COIN: begin
                    if (r_cnt == '0) begin
                        r_remain     <= r_remain - coin_units(r_coin_out);
                        r_coin_out   <= 2'b00;
                        r_coin_valid <= 1'b0;
                        r_cnt        <= GAP_LD;
                        r_state      <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                S_GAP: begin
                    if (r_cnt == '0) begin
                        r_state <= S_CHG_SEL;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                S_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign dispense   = r_dispense;
    assign coin_out   = r_coin_out;
    assign coin_valid = r_coin_valid;
    assign busy       = r_busy;
    assign denied     = r_denied;
    assign credit_clr = r_credit_clr;
    assign done       = r_done;

endmodule

// File: tb/tb_vend_change_out.sv
// tb_vend_change_out
//   Directed and randomized transactions for vend_change_out. For each
//   transaction a reference model writes out the expected per-cycle output
//   vector and the hopper_ready pattern to apply, straight from the
//   price / greedy-change arithmetic; the bench then replays it cycle by cycle.
`timescale 1ns/1ps

module tb_vend_change_out;

    localparam int PRICE = 6;
    localparam int P     = 4;
    localparam int G     = 2;

    // Output vector layout: {busy, dispense, coin_valid, coin_out[1:0], denied, credit_clr, done}
    localparam logic [7:0] V_BUSY = 8'h80;
    localparam logic [7:0] V_DISP = 8'h40;
    localparam logic [7:0] V_CV   = 8'h20;
    localparam logic [7:0] V_DEN  = 8'h04;
    localparam logic [7:0] V_CLR  = 8'h02;
    localparam logic [7:0] V_DONE = 8'h01;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] credit_in;
    logic       vend_req;
    logic       cancel_req;
    logic       hopper_ready;
    logic       dispense;
    logic [1:0] coin_out;
    logic       coin_valid;
    logic       busy;
    logic       denied;
    logic       credit_clr;
    logic       done;

    logic [7:0] obs;
    assign obs = {busy, dispense, coin_valid, coin_out, denied, credit_clr, done};

    int nvec = 0;
    int nmis = 0;

    logic [7:0] expq[$];
    bit         hq[$];   // hq[j]: hopper_ready applied for the edge ending cycle j

    always #5 clk = ~clk;

    vend_change_out #(
        .PRICE_N     (PRICE),
        .PULSE_CYCLES(P),
        .GAP_CYCLES  (G)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .credit_in   (credit_in),
        .vend_req    (vend_req),
        .cancel_req  (cancel_req),
        .hopper_ready(hopper_ready),
        .dispense    (dispense),
        .coin_out    (coin_out),
        .coin_valid  (coin_valid),
        .busy        (busy),
        .denied      (denied),
        .credit_clr  (credit_clr),
        .done        (done)
    );

    task automatic check(input string tag, input logic [7:0] e);
        nvec++;
        assert (obs === e) else begin
            nmis++;
            $error("FAIL %s: observed %b expected %b", tag, obs, e);
        end
    endtask

    task automatic push(input logic [7:0] v, input bit h);
        expq.push_back(v);
        hq.push_back(h);
    endtask

    function automatic bit rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Reference model: lays out the whole transaction as a cycle timeline.
    // dfix >= 0 fixes the hopper wait before every coin, else it is random.
    // hop_low forces hopper_ready low during coin pulses.
    task automatic build(input int credit, input bit vend, input bit cancel,
                         input int dfix, input bit hop_low);
        int rem;
        expq.delete();
        hq.delete();
        if (cancel) begin
            rem = credit;
        end else if (vend && credit >= PRICE) begin
            rem = credit - PRICE;
            repeat (P) push(V_BUSY | V_DISP, rbit());
        end else begin
            if (vend) push(V_DEN, rbit());
            push(8'h00, rbit());
            return;
        end
        while (rem > 0) begin
            int d;
            int val;
            logic [1:0] code;
            d = (dfix >= 0) ? dfix : int'($urandom_range(0, 3));
            repeat (d) push(V_BUSY, 1'b0);
            push(V_BUSY, 1'b1);
            if (rem >= 5) begin
                val = 5; code = 2'b11;
            end else if (rem >= 2) begin
                val = 2; code = 2'b10;
            end else begin
                val = 1; code = 2'b01;
            end
            repeat (P) push(V_BUSY | V_CV | {3'b000, code, 3'b000}, hop_low ? 1'b0 : rbit());
            repeat (G) push(V_BUSY, rbit());
            rem -= val;
        end
        push(V_BUSY, rbit());
        push(V_BUSY | V_CLR | V_DONE, rbit());
        push(8'h00, rbit());
    endtask

    // abort_at >= 0 asserts reset right after checking that cycle.
    task automatic run(input string tag, input int credit, input bit vend, input bit cancel,
                       input int dfix, input bit hop_low, input int abort_at);
        build(credit, vend, cancel, dfix, hop_low);
        credit_in    = 4'(credit);
        vend_req     = vend;
        cancel_req   = cancel;
        hopper_ready = rbit();
        for (int j = 0; j < expq.size(); j++) begin
            @(posedge clk);
            #1;
            vend_req     = 1'b0;
            cancel_req   = 1'b0;
            credit_in    = 4'($urandom_range(0, 15));
            hopper_ready = hq[j];
            check(tag, expq[j]);
            if (j == abort_at) begin
                rst_n = 1'b0;
                @(posedge clk);
                #1;
                check({tag, "_in_reset"}, 8'h00);
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                check({tag, "_after_reset"}, 8'h00);
                return;
            end
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        credit_in    = 4'd0;
        vend_req     = 1'b0;
        cancel_req   = 1'b0;
        hopper_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 8'h00);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_reset", 8'h00);

        run("exact_price",  6,  1'b1, 1'b0, 0,  1'b0, -1);
        run("max_change",   15, 1'b1, 1'b0, 0,  1'b0, -1);
        run("refund_13",    13, 1'b1, 1'b1, 0,  1'b0, -1);
        run("denied_5",     5,  1'b1, 1'b0, 0,  1'b0, -1);
        run("backpressure", 8,  1'b1, 1'b0, 10, 1'b1, -1);
        run("refund_zero",  0,  1'b0, 1'b1, 0,  1'b0, -1);
        run("denied_0",     0,  1'b1, 1'b0, 0,  1'b0, -1);
        run("no_request",   9,  1'b0, 1'b0, 0,  1'b0, -1);
        // Cycle 13 is the second of four cycles of the second coin pulse.
        run("reset_mid",    15, 1'b1, 1'b0, 0,  1'b0, 13);
        run("post_reset",   6,  1'b1, 1'b0, 0,  1'b0, -1);

        for (int k = 0; k < 40; k++) begin
            run("random", int'($urandom_range(0, 15)), rbit(),
                ($urandom_range(0, 3) == 0), -1, 1'b0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
